// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sequencer
//  Brief    : Sequences byte/half/word/doubleword requests onto an
//             asynchronous mfa/mfc RAM handshake with alignment, range and
//             timeout checking.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sequencer #(
    parameter int ADDRESS_SIZE = 9,
    parameter int RAM_SIZE     = 512,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req,
    input  logic                    req_rw,
    input  logic [1:0]              req_size,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [63:0]             req_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic [63:0]             rdata,
    output logic                    mem_mfa,
    output logic                    mem_rw,
    output logic [1:0]              mem_byte_mode,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [31:0]             mem_data_in,
    input  logic                    mem_mfc,
    input  logic [31:0]             mem_data_out
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_check   = 3'd1;
    localparam logic [2:0] c_st_setup   = 3'd2;
    localparam logic [2:0] c_st_strobe  = 3'd3;
    localparam logic [2:0] c_st_release = 3'd4;
    localparam logic [2:0] c_st_finish  = 3'd5;

    localparam logic [1:0] c_size_word  = 2'b00;
    localparam logic [1:0] c_size_byte  = 2'b01;
    localparam logic [1:0] c_size_half  = 2'b10;
    localparam logic [1:0] c_size_dword = 2'b11;

    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_align   = 2'b01;
    localparam logic [1:0] c_err_range   = 2'b10;
    localparam logic [1:0] c_err_timeout = 2'b11;

    localparam int                c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [2:0]              r_state;
    logic                    r_rw;
    logic [1:0]              r_size;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [63:0]             r_wdata;
    logic                    r_second;
    logic [31:0]             r_data_hi;
    logic [31:0]             r_data_lo;
    logic [1:0]              r_err;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_mfc_meta;
    logic                    r_mfc_sync;
    logic [63:0]             r_rdata;
    logic                    r_mem_rw;
    logic [1:0]              r_mem_byte_mode;
    logic [ADDRESS_SIZE-1:0] r_mem_addr;
    logic [31:0]             r_mem_data_in;

    logic [2:0]              w_state_next;
    logic [1:0]              w_err_next;
    logic                    w_load_setup;
    logic                    w_capture;
    logic                    w_second_half;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic [3:0]              w_nbytes;
    logic [31:0]             w_end;
    logic                    w_expired;
    logic [ADDRESS_SIZE-1:0] w_setup_addr;
    logic [31:0]             w_setup_data;
    logic [63:0]             w_rdata_next;
    logic                    w_rdata_load;

    always_comb begin
        w_misaligned = 1'b0;
        w_nbytes     = 4'd4;
        case (r_size)
            c_size_byte:  w_nbytes = 4'd1;
            c_size_half:  begin
                w_nbytes     = 4'd2;
                w_misaligned = r_addr[0];
            end
            c_size_word:  w_misaligned = (r_addr[1:0] != 2'b00);
            default: begin
                w_nbytes     = 4'd8;
                w_misaligned = (r_addr[1:0] != 2'b00);
            end
        endcase
        w_end          = 32'(r_addr) + 32'(w_nbytes);
        w_out_of_range = (w_end > 32'(RAM_SIZE));
    end

    assign w_expired     = (r_cnt == c_cnt_last);
    assign w_second_half = (r_state == c_st_release);
    assign w_setup_addr  = w_second_half ? (r_addr + ADDRESS_SIZE'(4)) : r_addr;

    // Doubleword sends the upper word first, at the lower address.
    always_comb begin
        w_setup_data = r_wdata[31:0];
        if (r_size == c_size_dword && !w_second_half) begin
            w_setup_data = r_wdata[63:32];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        w_load_setup = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req) begin
                    w_state_next = c_st_check;
                    w_err_next   = c_err_ok;
                end
            end
            c_st_check: begin
                if (w_misaligned) begin
                    w_state_next = c_st_finish;
                    w_err_next   = c_err_align;
                end else if (w_out_of_range) begin
                    w_state_next = c_st_finish;
                    w_err_next   = c_err_range;
                end else begin
                    w_state_next = c_st_setup;
                    w_load_setup = 1'b1;
                end
            end
            c_st_setup: w_state_next = c_st_strobe;
            c_st_strobe: begin
                if (r_mfc_sync) begin
                    w_state_next = c_st_release;
                    w_capture    = 1'b1;
                end else if (w_expired) begin
                    w_state_next = c_st_finish;
                    w_err_next   = c_err_timeout;
                end
            end
            c_st_release: begin
                if (!r_mfc_sync) begin
                    if (r_size == c_size_dword && !r_second) begin
                        w_state_next = c_st_setup;
                        w_load_setup = 1'b1;
                    end else begin
                        w_state_next = c_st_finish;
                    end
                end else if (w_expired) begin
                    w_state_next = c_st_finish;
                    w_err_next   = c_err_timeout;
                end
            end
            c_st_finish: w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        case (r_size)
            c_size_byte: w_rdata_next = {56'd0, r_data_hi[7:0]};
            c_size_half: w_rdata_next = {48'd0, r_data_hi[15:0]};
            c_size_word: w_rdata_next = {32'd0, r_data_hi};
            default:     w_rdata_next = {r_data_hi, r_data_lo};
        endcase
    end

    // Loaded on the edge into FINISH so rdata is valid alongside done.
    assign w_rdata_load = (w_state_next == c_st_finish) && (r_state != c_st_finish) &&
                          (w_err_next == c_err_ok) && !r_rw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_st_idle;
            r_rw            <= 1'b0;
            r_size          <= 2'b00;
            r_addr          <= '0;
            r_wdata         <= 64'd0;
            r_second        <= 1'b0;
            r_data_hi       <= 32'd0;
            r_data_lo       <= 32'd0;
            r_err           <= c_err_ok;
            r_cnt           <= '0;
            r_mfc_meta      <= 1'b0;
            r_mfc_sync      <= 1'b0;
            r_rdata         <= 64'd0;
            r_mem_rw        <= 1'b0;
            r_mem_byte_mode <= 2'b00;
            r_mem_addr      <= '0;
            r_mem_data_in   <= 32'd0;
        end else begin
            r_mfc_meta <= mem_mfc;
            r_mfc_sync <= r_mfc_meta;
            r_state    <= w_state_next;
            r_err      <= w_err_next;

            if (r_state == c_st_idle && req) begin
                r_rw     <= req_rw;
                r_size   <= req_size;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_second <= 1'b0;
            end

            if (w_load_setup) begin
                r_second        <= w_second_half;
                r_mem_addr      <= w_setup_addr;
                r_mem_rw        <= r_rw;
                r_mem_data_in   <= w_setup_data;
                r_mem_byte_mode <= (r_size == c_size_dword) ? c_size_word : r_size;
            end

            if (w_capture && !r_rw) begin
                if (r_second) begin
                    r_data_lo <= mem_data_out;
                end else begin
                    r_data_hi <= mem_data_out;
                end
            end

            if ((w_state_next == c_st_strobe || w_state_next == c_st_release) &&
                (w_state_next != r_state)) begin
                r_cnt <= '0;
            end else if (r_state == c_st_strobe || r_state == c_st_release) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_rdata_load) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign busy          = (r_state != c_st_idle);
    assign done          = (r_state == c_st_finish);
    assign err           = r_err;
    assign rdata         = r_rdata;
    assign mem_mfa       = (r_state == c_st_strobe);
    assign mem_rw        = r_mem_rw;
    assign mem_byte_mode = r_mem_byte_mode;
    assign mem_addr      = r_mem_addr;
    assign mem_data_in   = r_mem_data_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sequencer
//  Brief    : Directed self-checking bench for mem_sequencer with a
//             behavioural mfa/mfc RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    localparam int ADDRESS_SIZE = 9;
    localparam int RAM_SIZE     = 512;
    localparam int TIMEOUT      = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    req;
    logic                    req_rw;
    logic [1:0]              req_size;
    logic [ADDRESS_SIZE-1:0] req_addr;
    logic [63:0]             req_wdata;
    logic                    busy;
    logic                    done;
    logic [1:0]              err;
    logic [63:0]             rdata;
    logic                    mem_mfa;
    logic                    mem_rw;
    logic [1:0]              mem_byte_mode;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [31:0]             mem_data_in;
    logic                    mem_mfc      = 1'b0;
    logic [31:0]             mem_data_out = 32'd0;

    mem_sequencer #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .RAM_SIZE     (RAM_SIZE),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_rw        (req_rw),
        .req_size      (req_size),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rdata         (rdata),
        .mem_mfa       (mem_mfa),
        .mem_rw        (mem_rw),
        .mem_byte_mode (mem_byte_mode),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_mfc       (mem_mfc),
        .mem_data_out  (mem_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Big-endian byte RAM; mfc rises one half-cycle after mfa, drops after mfa.
    logic [7:0]              ram [0:RAM_SIZE-1];
    logic                    stuck = 1'b0;
    logic                    prev_mfa = 1'b0;
    int                      cyc = 0;
    int                      mfa_pulses = 0;
    int                      mfa_high = 0;
    int                      done_cnt = 0;
    logic [ADDRESS_SIZE-1:0] pulse_addr [0:63];
    int                      pulse_cyc  [0:63];
    logic [ADDRESS_SIZE-1:0] a1, a2, a3;

    assign a1 = mem_addr + ADDRESS_SIZE'(1);
    assign a2 = mem_addr + ADDRESS_SIZE'(2);
    assign a3 = mem_addr + ADDRESS_SIZE'(3);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_mfa && !prev_mfa) begin
            if (mfa_pulses < 64) begin
                pulse_addr[mfa_pulses] <= mem_addr;
                pulse_cyc[mfa_pulses]  <= cyc;
            end
            mfa_pulses <= mfa_pulses + 1;
        end
        if (mem_mfa) mfa_high <= mfa_high + 1;
        if (done)    done_cnt <= done_cnt + 1;
        prev_mfa <= mem_mfa;
        if (mem_mfa && !mem_mfc && !stuck) begin
            mem_mfc <= 1'b1;
            if (mem_rw) begin
                case (mem_byte_mode)
                    2'b01: ram[mem_addr] <= mem_data_in[7:0];
                    2'b10: begin
                        ram[mem_addr] <= mem_data_in[15:8];
                        ram[a1]       <= mem_data_in[7:0];
                    end
                    2'b00: begin
                        ram[mem_addr] <= mem_data_in[31:24];
                        ram[a1]       <= mem_data_in[23:16];
                        ram[a2]       <= mem_data_in[15:8];
                        ram[a3]       <= mem_data_in[7:0];
                    end
                    default: ;
                endcase
            end else begin
                case (mem_byte_mode)
                    2'b01:   mem_data_out <= {24'd0, ram[mem_addr]};
                    2'b10:   mem_data_out <= {16'd0, ram[mem_addr], ram[a1]};
                    default: mem_data_out <= {ram[mem_addr], ram[a1], ram[a2], ram[a3]};
                endcase
            end
        end else if (!mem_mfa && mem_mfc) begin
            mem_mfc <= 1'b0;
        end
    end

    int last_done_cyc = 0;

    task automatic do_req(input logic rw, input logic [1:0] size, input logic [ADDRESS_SIZE-1:0] addr,
                          input logic [63:0] wdata, output logic [1:0] e, output logic [63:0] rd);
        int n;
        @(negedge clk);
        req       = 1'b1;
        req_rw    = rw;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_done_cyc = cyc;
        check_val("done_seen", {63'd0, done}, 64'd1);
        e  = err;
        rd = rdata;
        @(negedge clk);
    endtask

    logic [1:0]  e;
    logic [63:0] rd;
    int          p0;
    int          h0;
    int          d0;
    int          n;

    initial begin
        reset_n   = 1'b0;
        req       = 1'b0;
        req_rw    = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_wdata = 64'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",  {63'd0, busy},    64'd0);
        check_val("rst_done",  {63'd0, done},    64'd0);
        check_val("rst_err",   {62'd0, err},     64'd0);
        check_val("rst_rdata", rdata,            64'd0);
        check_val("rst_mfa",   {63'd0, mem_mfa}, 64'd0);
        check_val("rst_addr",  64'(mem_addr),    64'd0);
        reset_n = 1'b1;

        do_req(1'b1, 2'b00, 9'h010, 64'h00000000DEADBEEF, e, rd);
        check_val("wr_word_err", 64'(e), 64'd0);
        do_req(1'b0, 2'b00, 9'h010, 64'd0, e, rd);
        check_val("rd_word_err",   64'(e), 64'd0);
        check_val("rd_word_rdata", rd,     64'h00000000DEADBEEF);

        do_req(1'b0, 2'b10, 9'h012, 64'd0, e, rd);
        check_val("rd_half_rdata", rd, 64'h000000000000BEEF);

        p0 = mfa_pulses;
        do_req(1'b1, 2'b11, 9'h020, 64'h1122334455667788, e, rd);
        check_val("wr_dw_err",    64'(e),            64'd0);
        check_val("wr_dw_pulses", 64'(mfa_pulses - p0), 64'd2);
        check_val("wr_dw_addr0",  64'(pulse_addr[p0]),     64'h020);
        check_val("wr_dw_addr1",  64'(pulse_addr[p0 + 1]), 64'h024);
        check_val("wr_dw_ram", {ram[9'h020], ram[9'h021], ram[9'h022], ram[9'h023],
                                ram[9'h024], ram[9'h025], ram[9'h026], ram[9'h027]},
                  64'h1122334455667788);
        p0 = mfa_pulses;
        do_req(1'b0, 2'b11, 9'h020, 64'd0, e, rd);
        check_val("rd_dw_pulses", 64'(mfa_pulses - p0), 64'd2);
        check_val("rd_dw_addr1",  64'(pulse_addr[p0 + 1]), 64'h024);
        check_val("rd_dw_rdata",  rd, 64'h1122334455667788);

        p0 = mfa_pulses;
        do_req(1'b0, 2'b10, 9'h003, 64'd0, e, rd);
        check_val("mis_half_err",   64'(e), 64'd1);
        check_val("mis_half_hold",  rd,     64'h1122334455667788);
        do_req(1'b1, 2'b11, 9'h1FC, 64'hFFFF, e, rd);
        check_val("range_dw_err", 64'(e), 64'd2);
        do_req(1'b0, 2'b00, 9'h1FE, 64'd0, e, rd);
        check_val("mis_over_range_err", 64'(e), 64'd1);
        check_val("err_no_mfa", 64'(mfa_pulses - p0), 64'd0);

        stuck = 1'b1;
        p0 = mfa_pulses;
        h0 = mfa_high;
        do_req(1'b0, 2'b10, 9'h010, 64'd0, e, rd);
        check_val("to_err",       64'(e), 64'd3);
        check_val("to_latency",   64'(last_done_cyc - pulse_cyc[p0]), 64'(TIMEOUT));
        check_val("to_mfa_width", 64'(mfa_high - h0), 64'(TIMEOUT));
        check_val("to_mfa_low",   {63'd0, mem_mfa}, 64'd0);
        stuck = 1'b0;
        do_req(1'b0, 2'b00, 9'h010, 64'd0, e, rd);
        check_val("after_to_err",   64'(e), 64'd0);
        check_val("after_to_rdata", rd,     64'h00000000DEADBEEF);

        do_req(1'b1, 2'b01, 9'h1FF, 64'h00000000000000A5, e, rd);
        check_val("wr_byte_err", 64'(e), 64'd0);
        do_req(1'b0, 2'b01, 9'h1FF, 64'd0, e, rd);
        check_val("rd_byte_err",   64'(e), 64'd0);
        check_val("rd_byte_rdata", rd,     64'h00000000000000A5);

        // Reset while a doubleword write is stuck in STROBE.
        stuck = 1'b1;
        @(negedge clk);
        req       = 1'b1;
        req_rw    = 1'b1;
        req_size  = 2'b11;
        req_addr  = 9'h040;
        req_wdata = 64'hCAFEF00D12345678;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!mem_mfa && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_mid_mfa_up", {63'd0, mem_mfa}, 64'd1);
        #1;
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_mfa",   {63'd0, mem_mfa}, 64'd0);
        check_val("rst_mid_busy",  {63'd0, busy},    64'd0);
        check_val("rst_mid_done",  {63'd0, done},    64'd0);
        check_val("rst_mid_addr",  64'(mem_addr),    64'd0);
        check_val("rst_mid_rdata", rdata,            64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        stuck   = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_val("rst_no_done",  64'(done_cnt - d0), 64'd0);
        check_val("rst_idle",     {63'd0, busy},      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
